// File: rtl/bus_master_if.sv
// CPU-side request/response and system-bus control signals of bus_master.
// bus_data is not in here: the tristate net stays a plain inout on the module.
interface bus_master_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic        cpu_err;
    logic        bus_request;
    logic        bus_r_w;
    logic [31:0] bus_address;
    logic        bus_ready;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_ready,
        output cpu_rdata, cpu_busy, cpu_done, cpu_err,
        output bus_request, bus_r_w, bus_address
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_ready,
        input  cpu_rdata, cpu_busy, cpu_done, cpu_err,
        input  bus_request, bus_r_w, bus_address
    );
endinterface

// File: rtl/bus_master.sv
// Single-channel master: one CPU load/store -> one tristate bus transaction, with a quiet
// period after reset/abort. Define BUS_TIMEOUT_EN to abort BUSY after TIMEOUT cycles without ready.
module bus_master #(
    parameter int QUIET   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         clrn,
    bus_master_if.master bm_if,
    inout  wire  [31:0]  bus_data
);
    typedef enum logic [1:0] {ST_QUIET, ST_IDLE, ST_BUSY, ST_DONE} state_t;

    localparam int QW = $clog2(QUIET);

    if (QUIET < 6) begin : g_quiet_chk
        $error("bus_master: QUIET must be at least 6");
    end
    if (TIMEOUT < 2) begin : g_tout_chk
        $error("bus_master: TIMEOUT must be at least 2");
    end

    state_t        state_q;
    logic [QW-1:0] quiet_cnt_q;
    logic          request_q;
    logic          r_w_q;
    logic [31:0]   address_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          bus_drive;

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] tout_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q     <= ST_QUIET;
            quiet_cnt_q <= '0;
            request_q   <= 1'b0;
            r_w_q       <= 1'b0;
            address_q   <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            tout_cnt_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_QUIET: begin
                    if (quiet_cnt_q == QW'(QUIET - 1)) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        quiet_cnt_q <= '0;
                    end else begin
                        quiet_cnt_q <= quiet_cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bm_if.cpu_req) begin
                        state_q   <= ST_BUSY;
                        busy_q    <= 1'b1;
                        request_q <= 1'b1;
                        r_w_q     <= bm_if.cpu_we;
                        address_q <= bm_if.cpu_addr;
                        wdata_q   <= bm_if.cpu_wdata;
`ifdef BUS_TIMEOUT_EN
                        tout_cnt_q <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    // Ready is checked first so it wins over a coincident timeout.
                    if (bm_if.bus_ready) begin
                        state_q   <= ST_DONE;
                        request_q <= 1'b0;
                        r_w_q     <= 1'b0;
                        address_q <= '0;
                        done_q    <= 1'b1;
                        if (!r_w_q) begin
                            rdata_q <= bus_data;
                        end
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tout_cnt_q == TW'(TIMEOUT - 1)) begin
                        state_q     <= ST_QUIET;
                        quiet_cnt_q <= '0;
                        request_q   <= 1'b0;
                        r_w_q       <= 1'b0;
                        address_q   <= '0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                    end else begin
                        tout_cnt_q <= tout_cnt_q + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    // One request-low cycle so the slave is idle before the next acceptance.
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_QUIET;
                end
            endcase
        end
    end

    assign bus_drive = request_q & r_w_q;
    assign bus_data  = bus_drive ? wdata_q : 'z;

    assign bm_if.cpu_rdata   = rdata_q;
    assign bm_if.cpu_busy    = busy_q;
    assign bm_if.cpu_done    = done_q;
    assign bm_if.cpu_err     = err_q;
    assign bm_if.bus_request = request_q;
    assign bm_if.bus_r_w     = r_w_q;
    assign bm_if.bus_address = address_q;
endmodule
